// File: rtl/oak_foundation_reader.sv
// Snapshots the five oak_foundation constants, checks them against their golden encodings and
// streams the snapshot as bytes. Define OAK_READER_CHECKSUM_EN to append an XOR checksum byte.
module oak_foundation_reader #(
  parameter bit          MSB_FIRST        = 1'b1,
  parameter logic [31:0] PHOENIX_EXPECTED = 32'd999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] phi_in,
  input  logic [63:0] pi_in,
  input  logic [63:0] e_in,
  input  logic [63:0] trinity_in,
  input  logic [31:0] phoenix_id_in,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_mask
);

  localparam logic [63:0] PHI_GOLD  = 64'h3FF9E3779B97F4A8;
  localparam logic [63:0] PI_GOLD   = 64'h400921FB54442D18;
  localparam logic [63:0] E_GOLD    = 64'h4005BF0A8B145769;
  localparam logic [63:0] TRIN_GOLD = 64'h4008000000000000;
`ifdef OAK_READER_CHECKSUM_EN
  localparam logic [5:0]  LAST_IDX  = 6'd36;
`else
  localparam logic [5:0]  LAST_IDX  = 6'd35;
`endif

  typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, STREAM, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] phi_q, pi_q, e_q, trinity_q;
  logic [31:0] phoenix_q;
  logic [5:0]  cnt;
  logic [4:0]  mismatch;
  logic [7:0]  byte_sel;
  logic        xfer;
`ifdef OAK_READER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  function automatic logic [7:0] pick64(input logic [63:0] w, input logic [2:0] b);
    logic [2:0] idx;
    idx = MSB_FIRST ? 3'd7 - b : b;
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] pick32(input logic [31:0] w, input logic [1:0] b);
    logic [1:0] idx;
    idx = MSB_FIRST ? 2'd3 - b : b;
    return w[{idx, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: state_nxt = CHECK;
      CHECK:   state_nxt = STREAM;
      STREAM:  if (xfer && cnt == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == STREAM);
  assign busy      = (state == CAPTURE) || (state == CHECK) || (state == STREAM);
  assign done      = (state == DONE);
  assign xfer      = out_valid && out_ready;
  // Byte is a pure function of snapshot and counter, so it stays put while the sink stalls.
  assign out_data  = out_valid ? byte_sel : 8'h00;

  assign mismatch = {phoenix_q != PHOENIX_EXPECTED, trinity_q != TRIN_GOLD,
                     e_q != E_GOLD, pi_q != PI_GOLD, phi_q != PHI_GOLD};

  always_comb begin
    byte_sel = 8'h00;
    case (cnt[5:3])
      3'd0: byte_sel = pick64(phi_q, cnt[2:0]);
      3'd1: byte_sel = pick64(pi_q, cnt[2:0]);
      3'd2: byte_sel = pick64(e_q, cnt[2:0]);
      3'd3: byte_sel = pick64(trinity_q, cnt[2:0]);
      3'd4: begin
`ifdef OAK_READER_CHECKSUM_EN
        if (cnt[2]) byte_sel = csum;
        else        byte_sel = pick32(phoenix_q, cnt[1:0]);
`else
        byte_sel = pick32(phoenix_q, cnt[1:0]);
`endif
      end
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi_q     <= '0;
      pi_q      <= '0;
      e_q       <= '0;
      trinity_q <= '0;
      phoenix_q <= '0;
      cnt       <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
    end else begin
      if (state == CAPTURE) begin
        phi_q     <= phi_in;
        pi_q      <= pi_in;
        e_q       <= e_in;
        trinity_q <= trinity_in;
        phoenix_q <= phoenix_id_in;
        cnt       <= '0;
      end
      if (state == CHECK) begin
        fail_mask <= mismatch;
        pass      <= (mismatch == 5'b00000);
      end
      if (xfer) cnt <= cnt + 6'd1;
    end
  end

`ifdef OAK_READER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    csum <= '0;
    else if (state == CAPTURE)  csum <= '0;
    else if (xfer)              csum <= csum ^ out_data;
  end
`endif

endmodule

// File: tb/tb_oak_foundation_reader.sv
// Directed bench for oak_foundation_reader: vector table of constant sets plus handshake,
// restart-rejection and mid-pass reset sequences.
`timescale 1ns/1ps
module tb_oak_foundation_reader;

  localparam logic [63:0] G_PHI  = 64'h3FF9E3779B97F4A8;
  localparam logic [63:0] G_PI   = 64'h400921FB54442D18;
  localparam logic [63:0] G_E    = 64'h4005BF0A8B145769;
  localparam logic [63:0] G_TRIN = 64'h4008000000000000;
  localparam logic [31:0] G_PHX  = 32'd999;
`ifdef OAK_READER_CHECKSUM_EN
  localparam int NB = 37;
`else
  localparam int NB = 36;
`endif
  localparam int LAT   = NB + 3;
  localparam int LIMIT = 4 * NB + 20;

  logic        clk, rst, start, out_ready;
  logic [63:0] phi_in, pi_in, e_in, trinity_in;
  logic [31:0] phoenix_id_in;
  logic [7:0]  out_data;
  logic        out_valid, busy, done, pass;
  logic [4:0]  fail_mask;

  int checks = 0;
  int errors = 0;
  logic [7:0]   got [0:63];
  int           ntx, done_k, ndone;
  logic [287:0] exp_s;

  typedef struct {
    logic [63:0] phi, pi, e, trin;
    logic [31:0] phx;
    logic [4:0]  mask;
    logic        ps;
    int          ci;
    logic [7:0]  cb;
  } vec_t;
  vec_t vecs [5];

  oak_foundation_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .phi_in(phi_in), .pi_in(pi_in), .e_in(e_in), .trinity_in(trinity_in),
    .phoenix_id_in(phoenix_id_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [287:0] s, input int i);
    logic [7:0] x;
    if (i < 36) return s[8*(35-i) +: 8];
    x = 8'h00;
    for (int j = 0; j < 36; j++) x = x ^ s[8*(35-j) +: 8];
    return x;
  endfunction

  task automatic set_golden();
    phi_in = G_PHI; pi_in = G_PI; e_in = G_E; trinity_in = G_TRIN; phoenix_id_in = G_PHX;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_data"},  64'(out_data),  64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_done"},      64'(done),      64'(0));
    chk({tag, "_pass"},      64'(pass),      64'(0));
    chk({tag, "_fail_mask"}, 64'(fail_mask), 64'(0));
  endtask

  task automatic check_bytes(input string tag, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(model_byte(exp_s, i)));
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0,1 repeating.
  // mode 0: plain; mode 1: restart attempts + inputs changed after capture; mode 2: reset at byte 10.
  task automatic run_pass(input int pat, input int mode);
    logic       prev_hold;
    logic [7:0] prev_data;
    bit         rst_hit;
    prev_hold = 1'b0; prev_data = 8'h00; rst_hit = 1'b0;
    ntx = 0; done_k = -1; ndone = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    exp_s = {phi_in, pi_in, e_in, trinity_in, phoenix_id_in};
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rst) rst = 1'b0;
      out_ready = (pat == 0) ? 1'b1 : (((k-1) % 4 == 0) || ((k-1) % 4 == 3));
      if (mode == 1 && k == 2) begin
        phi_in = ~phi_in; pi_in = ~pi_in; e_in = ~e_in;
        trinity_in = ~trinity_in; phoenix_id_in = ~phoenix_id_in;
      end
      if (mode == 1 && k == 12) start = 1'b1;
      if (k == 1) chk("busy_in_capture", 64'(busy), 64'(1));
      if (prev_hold) begin
        chk($sformatf("hold_valid_k%0d", k), 64'(out_valid), 64'(1));
        chk($sformatf("hold_data_k%0d", k),  64'(out_data),  64'(prev_data));
      end
      if (mode == 2 && !rst_hit && out_valid && ntx == 10) begin
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        rst_hit = 1'b1;
      end
      if (!out_valid) chk($sformatf("idle_data_k%0d", k), 64'(out_data), 64'(0));
      if (done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          chk("transfers_at_done", 64'(ntx), 64'(NB));
        end
        if (mode == 1) start = 1'b1;
      end
      if (done_k >= 0 && k == done_k + 1) chk("busy_after_done", 64'(busy), 64'(0));
      if (out_valid && out_ready) begin
        if (ntx < 64) got[ntx] = out_data;
        ntx++;
      end
      prev_hold = out_valid && !out_ready && !rst;
      prev_data = out_data;
      if (done_k >= 0 && k >= done_k + 3) break;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    set_golden();

    vecs[0] = '{G_PHI, G_PI, G_E, G_TRIN, G_PHX, 5'b00000, 1'b1, 0, 8'h3F};
    vecs[1] = '{G_PHI, 64'h400921FB54442D19, G_E, G_TRIN, 32'd1000, 5'b10010, 1'b0, 15, 8'h19};
    vecs[2] = '{64'h0, 64'h0, 64'h0, 64'h0, 32'h0, 5'b11111, 1'b0, 35, 8'h00};
    vecs[3] = '{G_PHI, G_PI, G_E, 64'hC008000000000000, G_PHX, 5'b01000, 1'b0, 24, 8'hC0};
    vecs[4] = '{64'h3FF9E3779B97F4A9, G_PI, 64'h4005BF0A8B145768, G_TRIN, G_PHX,
                5'b00101, 1'b0, 7, 8'hA9};

    @(negedge clk);
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      phi_in = vecs[v].phi; pi_in = vecs[v].pi; e_in = vecs[v].e;
      trinity_in = vecs[v].trin; phoenix_id_in = vecs[v].phx;
      run_pass(0, 0);
      chk($sformatf("v%0d_transfers", v), 64'(ntx), 64'(NB));
      chk($sformatf("v%0d_done_cycle", v), 64'(done_k), 64'(LAT));
      chk($sformatf("v%0d_done_count", v), 64'(ndone), 64'(1));
      chk($sformatf("v%0d_fail_mask", v), 64'(fail_mask), 64'(vecs[v].mask));
      chk($sformatf("v%0d_pass", v), 64'(pass), 64'(vecs[v].ps));
      chk($sformatf("v%0d_hand_byte", v), 64'(got[vecs[v].ci]), 64'(vecs[v].cb));
      check_bytes($sformatf("v%0d", v), NB);
    end

    set_golden();
    run_pass(0, 0);
    chk("gold_byte0", 64'(got[0]), 64'(8'h3F));
    chk("gold_byte1", 64'(got[1]), 64'(8'hF9));
    chk("gold_byte32", 64'(got[32]), 64'(8'h00));
    chk("gold_byte33", 64'(got[33]), 64'(8'h00));
    chk("gold_byte34", 64'(got[34]), 64'(8'h03));
    chk("gold_byte35", 64'(got[35]), 64'(8'hE7));
`ifdef OAK_READER_CHECKSUM_EN
    chk("gold_checksum", 64'(got[36]), 64'(model_byte(exp_s, 36)));
`endif

    run_pass(1, 0);
    chk("stall_transfers", 64'(ntx), 64'(NB));
    chk("stall_done_count", 64'(ndone), 64'(1));
    chk("stall_pass", 64'(pass), 64'(1));
    check_bytes("stall", NB);

    run_pass(0, 1);
    chk("restart_transfers", 64'(ntx), 64'(NB));
    chk("restart_done_cycle", 64'(done_k), 64'(LAT));
    chk("restart_done_count", 64'(ndone), 64'(1));
    chk("restart_pass", 64'(pass), 64'(1));
    check_bytes("restart", NB);
    chk("restart_idle_busy", 64'(busy), 64'(0));
    set_golden();

    run_pass(0, 2);
    chk("rst_done_count", 64'(ndone), 64'(0));
    chk("rst_transfers", 64'(ntx), 64'(10));
    chk("rst_idle_busy", 64'(busy), 64'(0));
    check_bytes("rst_partial", 10);

    run_pass(0, 0);
    chk("post_rst_transfers", 64'(ntx), 64'(NB));
    chk("post_rst_done_cycle", 64'(done_k), 64'(LAT));
    chk("post_rst_pass", 64'(pass), 64'(1));
    chk("post_rst_fail_mask", 64'(fail_mask), 64'(0));
    check_bytes("post_rst", NB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oak_foundation_reader.md
Name: oak_foundation_reader

Overview:
- Consumer end of the oak_foundation constant bus (L1).
- On a start pulse it does four things:
  - snapshots the five constants (phi, pi, e, trinity, phoenix_id);
  - checks each one against the golden IEEE 754 encodings;
  - latches a pass/fail mask;
  - streams the snapshot out as bytes over a valid/ready interface.
- Used for on-chip self-test and host readback of the sacred-math roots.

Parameters:
- MSB_FIRST, 1, byte order within each word: 1 = most-significant byte first, 0 = least-significant first.
- PHOENIX_EXPECTED, 999, golden value for phoenix_id_in (32-bit).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a read pass
- phi_in  in  64  phi constant from oak_foundation
- pi_in  in  64  pi constant
- e_in  in  64  e constant
- trinity_in  in  64  trinity constant
- phoenix_id_in  in  32  phoenix id
- out_data  out  8  streamed byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the byte
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- pass  out  1  all five constants matched in the last pass
- fail_mask  out  5  per-constant mismatch flags: [0] phi, [1] pi, [2] e, [3] trinity, [4] phoenix_id

Behaviour:
- Reset: asynchronous, active-high.
  - State = IDLE.
  - out_data = 0, out_valid = 0, busy = 0, done = 0, pass = 0, fail_mask = 0.
  - Capture registers and byte counter cleared.
  - Reset asserted mid-pass aborts immediately; no partial done.
- FSM states: IDLE, CAPTURE, CHECK, STREAM, DONE.
- IDLE:
  - start = 1 -> CAPTURE next cycle; busy rises with the state change.
  - start is ignored in every other state.
- CAPTURE (1 cycle):
  - Registers all five inputs into a 288-bit snapshot.
  - Inputs may change afterwards without affecting the pass.
- CHECK (1 cycle):
  - Compares the snapshot against the goldens: phi 64'h3FF9E3779B97F4A8, pi 64'h400921FB54442D18, e 64'h4005BF0A8B145769, trinity 64'h4008000000000000, phoenix PHOENIX_EXPECTED.
  - Exact bitwise compare: fail_mask[i] = 1 on any bit difference.
  - pass = (fail_mask == 0), registered at the end of CHECK.
  - fail_mask and pass hold until the next CHECK or reset.
- STREAM:
  - Emits 36 bytes in order: phi (8), pi (8), e (8), trinity (8), phoenix_id (4).
  - Byte counter is 0..35 (6 bits).
  - A transfer occurs on a cycle where out_valid && out_ready.
  - out_valid stays high continuously in STREAM.
  - While out_ready = 0, out_data is held stable (AXI-style; valid never drops before acceptance).
  - Transfer of byte 35 -> DONE.
- DONE (1 cycle):
  - done = 1, out_valid = 0, busy = 0 in the following IDLE.
  - A start in the DONE cycle is ignored.
  - A start on the first IDLE cycle after DONE is accepted.
- Latency with start sampled at edge N and out_ready tied high:
  - CAPTURE at N+1, CHECK at N+2.
  - First byte valid at N+3, last byte at N+38.
  - done at N+39.
  - Total latency is 39 cycles.
- busy = 1 in CAPTURE, CHECK and STREAM.
- out_data = 0 whenever out_valid = 0.
- Mismatching constants are still streamed verbatim; checking never blocks streaming.

Optional Feature:
- Macro: OAK_READER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every transferred byte is maintained, cleared in CAPTURE.
  - After byte 35 the block emits one extra byte (index 36) equal to that XOR, under the same handshake.
  - The stream is then 37 bytes; done arrives at N+40 with out_ready high.
- Undefined: 36-byte stream, no checksum logic synthesised.

Test Plan:
- Golden inputs, out_ready = 1, MSB_FIRST = 1:
  - first byte 8'h3F, second 8'hF9;
  - bytes 32..35 = 00 00 03 E7;
  - done at start+39, pass = 1, fail_mask = 5'b00000.
- pi_in bit 0 flipped (64'h400921FB54442D19) and phoenix_id_in = 1000: fail_mask = 5'b10010, pass = 0, and byte 15 streamed as 8'h19.
- out_ready toggled 1,0,0,1 repeatedly:
  - out_data is unchanged while out_ready = 0;
  - exactly 36 transfers;
  - no byte duplicated or skipped;
  - done only after the 36th transfer.
- start pulsed again during STREAM and during DONE: both are ignored, one done per accepted start. Inputs changed after CAPTURE do not alter the streamed bytes.
- rst asserted at byte 10:
  - all outputs return to 0 asynchronously;
  - no done pulse;
  - a subsequent start produces a full, correct 36-byte pass.
- With OAK_READER_CHECKSUM_EN defined and golden inputs: 37 bytes, byte 36 equals the bench-computed XOR of bytes 0..35, and done arrives at start+40.
